vae_fxp_datapath: RTL and testbench
===================================

Name: vae_fxp_datapath

Overview:
- Time-multiplexed, single-MAC fixed-point datapath for the VAE core. It runs three phases:
  - encoder dense layer (N_ENC -> M_ENC)
  - reparameterisation sampling (z = mu + sigma*eps)
  - decoder dense layer (N_LAT -> M_DEC)
- Sits between the input-vector source and the output sigmoid stage, and exposes pre-activation decoder outputs.
- Weights and biases come from external constant registers.

Parameters:
- N_ENC, 9, encoder input count.
- M_ENC, 4, encoder output count; must equal 2*N_LAT.
- N_LAT, 2, latent size (decoder input count).
- M_DEC, 9, decoder output count.
- BITSIZE, 32, word width.
- FRAC, 26, fraction bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- x  in  N_ENC*BITSIZE  encoder input vector, captured at start
- eps  in  N_LAT*BITSIZE  noise vector, captured at start
- w_enc  in  N_ENC*M_ENC*BITSIZE  encoder weights; held stable while busy
- b_enc  in  M_ENC*BITSIZE  encoder biases
- w_dec  in  N_LAT*M_DEC*BITSIZE  decoder weights
- b_dec  in  M_DEC*BITSIZE  decoder biases
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse when results are valid
- enc_out  out  M_ENC*BITSIZE  encoder results
- z  out  N_LAT*BITSIZE  latent sample
- y  out  M_DEC*BITSIZE  decoder pre-activation results

Behaviour:
- Number format: every word is sign-magnitude.
  - bit 31 = sign; bits 30:26 = integer; bits 25:0 = fraction.
  - 1.0 = 0x04000000; -1.0 = 0x84000000.
- Indexing: element k of a vector is at [k*BITSIZE +: BITSIZE]. Weight from input i to output j is at [(j*N+i)*BITSIZE +: BITSIZE], where N is that layer's input count.
- Product: magnitude = (|a|*|b|) >> FRAC, truncated; sign = sign(a) XOR sign(b).
- Accumulator: signed two's-complement, at least 40 bits.
  - Initialised with the neuron bias.
  - Products added one per cycle in ascending i.
- Write-back: convert the accumulator to sign-magnitude.
  - Saturate magnitude to 0x7FFFFFFF.
  - Zero is always written as 0x00000000 (never -0).
- FSM states: IDLE -> ENC -> SAMP -> DEC -> DONE -> IDLE.
  - ENC: per neuron j, N_ENC MAC cycles plus 1 write cycle; M_ENC*(N_ENC+1) cycles total.
  - SAMP: 1 cycle per latent k; N_LAT cycles total.
    - mu_k = enc[2k]; sigma_k = enc[2k+1], clamped to 0 if its sign is negative.
    - z_k = mu_k + sigma_k*eps_k, using the same product/saturation rules.
  - DEC: M_DEC*(N_LAT+1) cycles, same scheme as ENC, with z as the input vector.
  - DONE: 1 cycle, done=1, busy=0; then IDLE.
- Latency: done rises exactly M_ENC*(N_ENC+1) + N_LAT + M_DEC*(N_LAT+1) + 1 rising edges after the start-accept edge. This is 70 for the defaults.
- Output timing: enc_out, z and y update only as their phase writes back; they hold value until overwritten by the next run.
- start while busy or in DONE: ignored, no queuing.
- start in the DONE cycle: ignored.
- Reset (rst_n low, any time, including mid-run):
  - FSM to IDLE; busy=0, done=0.
  - enc_out, z, y and the accumulator all cleared to 0.
  - No done is produced for the aborted run.

Test Plan:
- Reset: assert rst_n=0 mid-run -> busy=0, done=0, enc_out=z=y=0 immediately; no done pulse follows after release.
- Bias path: all weights 0, b_enc all 0x04000000, eps=0, b_dec all 0x84000000, start -> done exactly 70 cycles later; enc_out all 0x04000000, z all 0x04000000, y all 0x84000000.
- Sampling:
  - Setup: x0=0x08000000 (2.0), w_enc[j0,i0]=0x02000000 (0.5), w_enc[j1,i0]=0x04000000 (1.0), all else 0, eps0=0x02000000.
  - Response: enc0=1.0, enc1=2.0, z0=0x08000000 (2.0), z1=0.
- Sigma clamp: same as the sampling case but w_enc[j1,i0]=0x84000000 -> enc1=0x88000000, z0=0x04000000 (1.0).
- Saturation and sign: x0=0x7C000000 (31.0), w_enc[j0,i0]=0x7C000000 -> enc0=0x7FFFFFFF; with w_enc[j0,i0]=0xFC000000 -> enc0=0xFFFFFFFF. A result of -0 is written as 0x00000000.
- Handshake: pulse start again 10 cycles into a run -> ignored; single done at cycle 70, busy deasserts with done, and outputs hold afterwards.

Source files
------------

// File: rtl/vae_fxp_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : vae_fxp_datapath
//  Description : Time-multiplexed single-MAC sign-magnitude fixed-point
//                datapath for the VAE core. A run has three phases: the
//                encoder dense layer, reparameterisation sampling
//                (z = mu + sigma*eps) and the decoder dense layer. The
//                decoder results are pre-activation values.
//  Ports       : clk, rst_n             clock, async active-low reset
//                start                  one-cycle request, taken in IDLE only
//                x, eps                 input / noise vectors, captured at start
//                w_enc, b_enc           encoder weights / biases (held stable)
//                w_dec, b_dec           decoder weights / biases (held stable)
//                busy, done             run in progress / results-valid pulse
//                enc_out, z, y          encoder, latent, decoder results
//  Revision    : 1.0  initial release
// ============================================================================
module vae_fxp_datapath #(
    parameter int N_ENC   = 9,
    parameter int M_ENC   = 4,
    parameter int N_LAT   = 2,
    parameter int M_DEC   = 9,
    parameter int BITSIZE = 32,
    parameter int FRAC    = 26
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [N_ENC*BITSIZE-1:0]         x,
    input  logic [N_LAT*BITSIZE-1:0]         eps,
    input  logic [N_ENC*M_ENC*BITSIZE-1:0]   w_enc,
    input  logic [M_ENC*BITSIZE-1:0]         b_enc,
    input  logic [N_LAT*M_DEC*BITSIZE-1:0]   w_dec,
    input  logic [M_DEC*BITSIZE-1:0]         b_dec,
    output logic                             busy,
    output logic                             done,
    output logic [M_ENC*BITSIZE-1:0]         enc_out,
    output logic [N_LAT*BITSIZE-1:0]         z,
    output logic [M_DEC*BITSIZE-1:0]         y
);

    // Accumulator headroom: a full product is up to 2*(BITSIZE-1)-FRAC bits
    // of magnitude; twelve extra bits cover bias plus many such terms.
    localparam int c_AW = BITSIZE + 12;
    localparam int c_PW = 2 * (BITSIZE - 1);
    localparam int c_CW = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ENC  = 3'd1,
        S_SAMP = 3'd2,
        S_DEC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CW-1:0]           r_i;
    logic [c_CW-1:0]           r_j;
    logic signed [c_AW-1:0]    r_acc;
    logic [N_ENC*BITSIZE-1:0]  r_x;
    logic [N_LAT*BITSIZE-1:0]  r_eps;
    logic [M_ENC*BITSIZE-1:0]  r_enc;
    logic [N_LAT*BITSIZE-1:0]  r_z;
    logic [M_DEC*BITSIZE-1:0]  r_y;

    logic [BITSIZE-1:0]        w_op_a;
    logic [BITSIZE-1:0]        w_op_b;
    logic signed [c_AW-1:0]    w_base;
    logic signed [c_AW-1:0]    w_sum;
    logic                      w_enc_wr;
    logic                      w_dec_wr;
    logic                      w_enc_jlast;
    logic                      w_lat_jlast;
    logic                      w_dec_jlast;

    // Sign-magnitude word -> two's-complement accumulator value.
    function automatic logic signed [c_AW-1:0] sm_to_acc(input logic [BITSIZE-1:0] v);
        logic signed [c_AW-1:0] mag;
        mag = {{(c_AW-BITSIZE+1){1'b0}}, v[BITSIZE-2:0]};
        return v[BITSIZE-1] ? -mag : mag;
    endfunction

    // Sign-magnitude product, magnitude truncated after the FRAC shift.
    // A truncated-to-zero negative product becomes plain 0 here.
    function automatic logic signed [c_AW-1:0] sm_mul(input logic [BITSIZE-1:0] a,
                                                      input logic [BITSIZE-1:0] b);
        logic [c_PW-1:0]        ea;
        logic [c_PW-1:0]        eb;
        logic [c_PW-1:0]        full;
        logic signed [c_AW-1:0] mag;
        ea   = {{(BITSIZE-1){1'b0}}, a[BITSIZE-2:0]};
        eb   = {{(BITSIZE-1){1'b0}}, b[BITSIZE-2:0]};
        full = (ea * eb) >> FRAC;
        mag  = {1'b0, full[c_AW-2:0]};
        return (a[BITSIZE-1] ^ b[BITSIZE-1]) ? -mag : mag;
    endfunction

    // Accumulator -> saturated sign-magnitude word; zero never carries a sign.
    function automatic logic [BITSIZE-1:0] acc_to_sm(input logic signed [c_AW-1:0] a);
        logic [c_AW-1:0]    mag;
        logic [BITSIZE-2:0] m;
        mag = a[c_AW-1] ? -a : a;
        if (|mag[c_AW-1:BITSIZE-1]) m = '1;
        else                        m = mag[BITSIZE-2:0];
        if (m == '0) return '0;
        return {a[c_AW-1], m};
    endfunction

    assign w_enc_wr    = (r_i == c_CW'(N_ENC));
    assign w_dec_wr    = (r_i == c_CW'(N_LAT));
    assign w_enc_jlast = (r_j == c_CW'(M_ENC - 1));
    assign w_lat_jlast = (r_j == c_CW'(N_LAT - 1));
    assign w_dec_jlast = (r_j == c_CW'(M_DEC - 1));

    // Shared MAC operand selection. On the first MAC cycle of a neuron the
    // bias replaces the running accumulator as the addend.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        w_base = '0;
        case (r_state)
            S_ENC: begin
                if (r_i < c_CW'(N_ENC)) begin
                    w_op_a = r_x[int'(r_i)*BITSIZE +: BITSIZE];
                    w_op_b = w_enc[(int'(r_j)*N_ENC + int'(r_i))*BITSIZE +: BITSIZE];
                    w_base = (r_i == '0) ? sm_to_acc(b_enc[int'(r_j)*BITSIZE +: BITSIZE]) : r_acc;
                end
            end
            S_SAMP: begin
                // sigma with a set sign bit (including -0) is clamped to 0
                w_op_a = r_enc[(2*int'(r_j)+1)*BITSIZE +: BITSIZE];
                if (w_op_a[BITSIZE-1]) w_op_a = '0;
                w_op_b = r_eps[int'(r_j)*BITSIZE +: BITSIZE];
                w_base = sm_to_acc(r_enc[(2*int'(r_j))*BITSIZE +: BITSIZE]);
            end
            S_DEC: begin
                if (r_i < c_CW'(N_LAT)) begin
                    w_op_a = r_z[int'(r_i)*BITSIZE +: BITSIZE];
                    w_op_b = w_dec[(int'(r_j)*N_LAT + int'(r_i))*BITSIZE +: BITSIZE];
                    w_base = (r_i == '0) ? sm_to_acc(b_dec[int'(r_j)*BITSIZE +: BITSIZE]) : r_acc;
                end
            end
            default: ;
        endcase
        w_sum = w_base + sm_mul(w_op_a, w_op_b);
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ENC;
            S_ENC: begin
                busy = 1'b1;
                if (w_enc_wr && w_enc_jlast) w_state_nxt = S_SAMP;
            end
            S_SAMP: begin
                busy = 1'b1;
                if (w_lat_jlast) w_state_nxt = S_DEC;
            end
            S_DEC: begin
                busy = 1'b1;
                if (w_dec_wr && w_dec_jlast) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_x   <= '0;
            r_eps <= '0;
            r_enc <= '0;
            r_z   <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x <= x;
                        r_eps <= eps;
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                S_ENC: begin
                    if (w_enc_wr) begin
                        r_enc[int'(r_j)*BITSIZE +: BITSIZE] <= acc_to_sm(r_acc);
                        r_i <= '0;
                        r_j <= w_enc_jlast ? '0 : r_j + c_CW'(1);
                    end else begin
                        r_acc <= w_sum;
                        r_i   <= r_i + c_CW'(1);
                    end
                end
                S_SAMP: begin
                    r_z[int'(r_j)*BITSIZE +: BITSIZE] <= acc_to_sm(w_sum);
                    r_j <= w_lat_jlast ? '0 : r_j + c_CW'(1);
                end
                S_DEC: begin
                    if (w_dec_wr) begin
                        r_y[int'(r_j)*BITSIZE +: BITSIZE] <= acc_to_sm(r_acc);
                        r_i <= '0;
                        r_j <= w_dec_jlast ? '0 : r_j + c_CW'(1);
                    end else begin
                        r_acc <= w_sum;
                        r_i   <= r_i + c_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign enc_out = r_enc;
    assign z       = r_z;
    assign y       = r_y;

endmodule
`default_nettype wire

// File: tb/tb_vae_fxp_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vae_fxp_datapath
//  Description : Scoreboard bench for vae_fxp_datapath. Each run pushes its
//                hand-computed expected results; a negedge monitor pops and
//                compares on every done pulse (results and latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vae_fxp_datapath;

    localparam int N_ENC = 9;
    localparam int M_ENC = 4;
    localparam int N_LAT = 2;
    localparam int M_DEC = 9;
    localparam int BS    = 32;
    localparam int LAT   = 70;

    localparam logic [31:0] P1  = 32'h04000000;
    localparam logic [31:0] M1  = 32'h84000000;
    localparam logic [31:0] PH  = 32'h02000000;
    localparam logic [31:0] MH  = 32'h82000000;
    localparam logic [31:0] P2  = 32'h08000000;
    localparam logic [31:0] P31 = 32'h7C000000;

    typedef struct {
        logic [M_ENC*BS-1:0] enc;
        logic [N_LAT*BS-1:0] zz;
        logic [M_DEC*BS-1:0] yy;
        int                  t0;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic [N_ENC*BS-1:0]         x = '0;
    logic [N_LAT*BS-1:0]         eps = '0;
    logic [N_ENC*M_ENC*BS-1:0]   w_enc = '0;
    logic [M_ENC*BS-1:0]         b_enc = '0;
    logic [N_LAT*M_DEC*BS-1:0]   w_dec = '0;
    logic [M_DEC*BS-1:0]         b_dec = '0;
    logic                        busy;
    logic                        done;
    logic [M_ENC*BS-1:0]         enc_out;
    logic [N_LAT*BS-1:0]         z;
    logic [M_DEC*BS-1:0]         y;

    vae_fxp_datapath dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .eps(eps),
        .w_enc(w_enc), .b_enc(b_enc), .w_dec(w_dec), .b_dec(b_dec),
        .busy(busy), .done(done), .enc_out(enc_out), .z(z), .y(y)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    exp_t q[$];
    exp_t last_e;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h required %h", nm, idx, got, req);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        for (int k = 0; k < M_ENC; k++) chk({tag, "_enc"}, k, enc_out[k*BS +: BS], e.enc[k*BS +: BS]);
        for (int k = 0; k < N_LAT; k++) chk({tag, "_z"}, k, z[k*BS +: BS], e.zz[k*BS +: BS]);
        for (int k = 0; k < M_DEC; k++) chk({tag, "_y"}, k, y[k*BS +: BS], e.yy[k*BS +: BS]);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            chk("busy_at_done", 0, {31'b0, busy}, 32'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 required no pending run (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("latency", 0, cyc - mon_e.t0, LAT);
                chk_outputs("run", mon_e);
                last_e = mon_e;
            end
        end
    end

    // Start is presented in the cycle recorded as t0; done must appear in
    // cycle t0+70.
    task automatic launch(input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge clk);
        e.t0 = cyc;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (n_done > n0) break;
        end
        if (k == 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 200 cycles required done");
        end
    endtask

    task automatic clear_cfg();
        x = '0; eps = '0; w_enc = '0; b_enc = '0; w_dec = '0; b_dec = '0;
    endtask

    // Decoder used by the sampling-driven runs: y0 = z0, y1 = -0.5*z0, y2 = 0.5
    task automatic dec_cfg();
        w_dec[0*BS +: BS] = P1;
        w_dec[2*BS +: BS] = MH;
        b_dec[2*BS +: BS] = PH;
    endtask

    task automatic blank(output exp_t e);
        e.enc = '0; e.zz = '0; e.yy = '0; e.t0 = 0;
        e.yy[2*BS +: BS] = PH;
    endtask

    exp_t e;
    int   n0;

    initial begin
        // ---- reset state ----
        #12;
        chk("rst_busy", 0, {31'b0, busy}, 32'd0);
        chk("rst_done", 0, {31'b0, done}, 32'd0);
        for (int k = 0; k < M_ENC; k++) chk("rst_enc", k, enc_out[k*BS +: BS], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- bias path ----
        clear_cfg();
        for (int k = 0; k < N_ENC; k++) x[k*BS +: BS] = P1;
        for (int k = 0; k < M_ENC; k++) b_enc[k*BS +: BS] = P1;
        for (int k = 0; k < M_DEC; k++) b_dec[k*BS +: BS] = M1;
        e.t0 = 0;
        for (int k = 0; k < M_ENC; k++) e.enc[k*BS +: BS] = P1;
        for (int k = 0; k < N_LAT; k++) e.zz[k*BS +: BS] = P1;
        for (int k = 0; k < M_DEC; k++) e.yy[k*BS +: BS] = M1;
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- sampling ----
        clear_cfg(); dec_cfg();
        x[0*BS +: BS] = P2;
        w_enc[0*BS +: BS] = PH;
        w_enc[9*BS +: BS] = P1;
        eps[0*BS +: BS] = PH;
        eps[1*BS +: BS] = P1;
        blank(e);
        e.enc[0*BS +: BS] = P1; e.enc[1*BS +: BS] = P2;
        e.zz[0*BS +: BS] = P2;
        e.yy[0*BS +: BS] = P2; e.yy[1*BS +: BS] = M1;
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- sigma clamp ----
        w_enc[9*BS +: BS] = M1;
        blank(e);
        e.enc[0*BS +: BS] = P1; e.enc[1*BS +: BS] = 32'h88000000;
        e.zz[0*BS +: BS] = P1;
        e.yy[0*BS +: BS] = P1; e.yy[1*BS +: BS] = MH;
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- positive saturation ----
        clear_cfg(); dec_cfg();
        x[0*BS +: BS] = P31;
        w_enc[0*BS +: BS] = P31;
        blank(e);
        e.enc[0*BS +: BS] = 32'h7FFFFFFF;
        e.zz[0*BS +: BS] = 32'h7FFFFFFF;
        e.yy[0*BS +: BS] = 32'h7FFFFFFF; e.yy[1*BS +: BS] = 32'hBFFFFFFF;
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- negative saturation ----
        w_enc[0*BS +: BS] = 32'hFC000000;
        blank(e);
        e.enc[0*BS +: BS] = 32'hFFFFFFFF;
        e.zz[0*BS +: BS] = 32'hFFFFFFFF;
        e.yy[0*BS +: BS] = 32'hFFFFFFFF; e.yy[1*BS +: BS] = 32'h3FFFFFFF;
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- zero results are never -0 ----
        clear_cfg(); dec_cfg();
        x[0*BS +: BS] = P1; x[1*BS +: BS] = P1;
        w_enc[0*BS +: BS] = P1; w_enc[1*BS +: BS] = M1;
        b_enc[1*BS +: BS] = 32'h80000000;
        eps[0*BS +: BS] = MH;
        blank(e);
        n0 = n_done;
        launch(e);
        wait_done(n0);

        // ---- handshake: start mid-run and in DONE are ignored ----
        clear_cfg(); dec_cfg();
        x[0*BS +: BS] = P2;
        w_enc[0*BS +: BS] = PH;
        w_enc[9*BS +: BS] = P1;
        eps[0*BS +: BS] = PH;
        blank(e);
        e.enc[0*BS +: BS] = P1; e.enc[1*BS +: BS] = P2;
        e.zz[0*BS +: BS] = P2;
        e.yy[0*BS +: BS] = P2; e.yy[1*BS +: BS] = M1;
        n0 = n_done;
        launch(e);
        repeat (9) @(negedge clk);
        chk("busy_midrun", 0, {31'b0, busy}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        start = 1'b1;               // still inside the DONE cycle
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_done_start", 0, {31'b0, busy}, 32'd0);
        repeat (80) @(negedge clk);
        #1;
        chk("single_done", 0, n_done, n0 + 1);
        chk_outputs("hold", last_e);

        // ---- asynchronous reset mid-run ----
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, {31'b0, busy}, 32'd0);
        chk("abort_done", 0, {31'b0, done}, 32'd0);
        blank(e);
        e.yy[2*BS +: BS] = '0;
        chk_outputs("abort", e);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_done;
        repeat (100) @(negedge clk);
        #1;
        chk("no_done_after_abort", 0, n_done, n0);
        chk("idle_after_abort", 0, {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
